// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit multiplexed seven-segment scan driver.
// Double-buffered data (staging -> active at frame boundary), per-digit enable
// and decimal point, anti-ghost blanking at slot start, 16-level PWM
// brightness, selectable output polarity and a frame_start strobe.
// Handshake: load is a single-cycle strobe with no back-pressure; every
// strobe is accepted into staging, and the last one before a frame boundary
// is the one that goes active.
module seg_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_CNT = 100_000,
    parameter int BLANK_CNT   = 1_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              c,
    output logic                    dp_out,
    output logic                    frame_start
);

    localparam int SW   = $clog2(REFRESH_CNT);
    localparam int SELW = $clog2(N_DIGITS);
    localparam logic [SW-1:0]   SLOT_LAST = SW'(REFRESH_CNT - 1);
    localparam logic [SW-1:0]   BLANK_END = SW'(BLANK_CNT);
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(N_DIGITS - 1);
    // XOR mask turning active-high internal values into pin polarity
    localparam logic            POL       = (ACTIVE_LOW != 0);

    // Active-low segment patterns {ca..cg}
    function automatic logic [6:0] font_lo(input logic [3:0] v);
        case (v)
            4'h0: font_lo = 7'h01;
            4'h1: font_lo = 7'h4F;
            4'h2: font_lo = 7'h12;
            4'h3: font_lo = 7'h06;
            4'h4: font_lo = 7'h4C;
            4'h5: font_lo = 7'h24;
            4'h6: font_lo = 7'h20;
            4'h7: font_lo = 7'h0F;
            4'h8: font_lo = 7'h00;
            4'h9: font_lo = 7'h04;
            4'hA: font_lo = 7'h08;
            4'hB: font_lo = 7'h60;
            4'hC: font_lo = 7'h31;
            4'hD: font_lo = 7'h42;
            4'hE: font_lo = 7'h30;
            default: font_lo = 7'h38;
        endcase
    endfunction

    logic [SW-1:0]          slot_cnt_q, slot_cnt_d;
    logic [SELW-1:0]        sel_q, sel_d;
    logic [3:0]             pwm_cnt_q, pwm_cnt_d;
    logic                   slot_wrap, frame_bnd;

    logic [4*N_DIGITS-1:0]  stg_digits_q, stg_digits_d;
    logic [N_DIGITS-1:0]    stg_dp_q, stg_dp_d;
    logic [N_DIGITS-1:0]    stg_en_q, stg_en_d;
    logic [3:0]             stg_bright_q, stg_bright_d;
    logic                   pending_q, pending_d;

    logic [4*N_DIGITS-1:0]  act_digits_q, act_digits_d;
    logic [N_DIGITS-1:0]    act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]    act_en_q, act_en_d;
    logic [3:0]             act_bright_q, act_bright_d;

    logic                   lit;
    logic [N_DIGITS-1:0]    an_hi;
    logic [6:0]             seg_hi;
    logic                   dp_hi;
    logic [N_DIGITS-1:0]    an_q, an_d;
    logic [6:0]             c_q, c_d;
    logic                   dp_out_q, dp_out_d;
    logic                   frame_start_q, frame_start_d;

    // Slot counter, digit select and PWM phase (PWM restarts at every slot)
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_LAST);
        frame_bnd  = slot_wrap && (sel_q == SEL_LAST);
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);
        sel_d      = sel_q;
        if (slot_wrap) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
        end
        pwm_cnt_d  = slot_wrap ? 4'd0 : pwm_cnt_q + 4'd1;
    end

    // Staging capture on load; staging promoted to active only at frame boundary
    always_comb begin
        stg_digits_d = stg_digits_q;
        stg_dp_d     = stg_dp_q;
        stg_en_d     = stg_en_q;
        stg_bright_d = stg_bright_q;
        pending_d    = pending_q;
        act_digits_d = act_digits_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        act_bright_d = act_bright_q;
        // Promotion uses the old staging, so a coincident load waits a frame
        if (frame_bnd && pending_q) begin
            act_digits_d = stg_digits_q;
            act_dp_d     = stg_dp_q;
            act_en_d     = stg_en_q;
            act_bright_d = stg_bright_q;
        end
        if (frame_bnd) begin
            pending_d = 1'b0;
        end
        if (load) begin
            stg_digits_d = digits;
            stg_dp_d     = dp;
            stg_en_d     = digit_en;
            stg_bright_d = brightness;
            pending_d    = 1'b1;
        end
    end

    // Lit-window decode and pin drive values (registered one cycle later)
    always_comb begin
        lit = (slot_cnt_q >= BLANK_END) && act_en_q[sel_q] &&
              ((act_bright_q == 4'hF) || (pwm_cnt_q < act_bright_q));
        an_hi = '0;
        if (lit) begin
            an_hi[sel_q] = 1'b1;
        end
        seg_hi        = lit ? ~font_lo(act_digits_q[{sel_q, 2'b00} +: 4]) : 7'h00;
        dp_hi         = lit && act_dp_q[sel_q];
        an_d          = an_hi ^ {N_DIGITS{POL}};
        c_d           = seg_hi ^ {7{POL}};
        dp_out_d      = dp_hi ^ POL;
        frame_start_d = frame_bnd;
    end

    // State registers; reset leaves all pins inactive and the display dark
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            sel_q         <= '0;
            pwm_cnt_q     <= 4'd0;
            stg_digits_q  <= '0;
            stg_dp_q      <= '0;
            stg_en_q      <= '0;
            stg_bright_q  <= 4'd0;
            pending_q     <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            act_bright_q  <= 4'd0;
            an_q          <= {N_DIGITS{POL}};
            c_q           <= {7{POL}};
            dp_out_q      <= POL;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            sel_q         <= sel_d;
            pwm_cnt_q     <= pwm_cnt_d;
            stg_digits_q  <= stg_digits_d;
            stg_dp_q      <= stg_dp_d;
            stg_en_q      <= stg_en_d;
            stg_bright_q  <= stg_bright_d;
            pending_q     <= pending_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            act_bright_q  <= act_bright_d;
            an_q          <= an_d;
            c_q           <= c_d;
            dp_out_q      <= dp_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign c           = c_q;
    assign dp_out      = dp_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with N_DIGITS=4, REFRESH_CNT=40, BLANK_CNT=4.
// Two instances share stimulus: active-low pins and active-high pins.
// Expected pin values are stamped with the absolute clock count at which
// they must appear; a monitor pops and compares on each falling edge.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int W  = 29;   // {stamp[15:0], fs, dp, c[6:0], an[3:0]}
    localparam int B1 = 3;    // clock count at first reset release
    localparam int B2 = B1 + 1545; // clock count at second reset release

    logic           ck;
    logic           rst_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   digit_en;
    logic [3:0]     brightness;
    logic           load;

    logic [N-1:0]   an0, an1;
    logic [6:0]     c0, c1;
    logic           dp0, dp1, fs0, fs1;

    int             cyc;
    int             checks;
    int             errors;
    int             base;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_e;
    int             mon_idx;

    seg_scan_driver #(.N_DIGITS(4), .REFRESH_CNT(40), .BLANK_CNT(4), .ACTIVE_LOW(1)) dut_lo (
        .ck(ck), .rst_n(rst_n), .digits(digits), .dp(dp), .digit_en(digit_en),
        .brightness(brightness), .load(load),
        .an(an0), .c(c0), .dp_out(dp0), .frame_start(fs0)
    );

    seg_scan_driver #(.N_DIGITS(4), .REFRESH_CNT(40), .BLANK_CNT(4), .ACTIVE_LOW(0)) dut_hi (
        .ck(ck), .rst_n(rst_n), .digits(digits), .dp(dp), .digit_en(digit_en),
        .brightness(brightness), .load(load),
        .an(an1), .c(c1), .dp_out(dp1), .frame_start(fs1)
    );

    // Clock and free-running cycle count
    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    // Scoreboard push helpers (values in active-low pin terms)
    task automatic push(input int t_abs, input logic [3:0] a, input logic [6:0] cc,
                        input logic d, input logic f);
        exp_q.push_back({16'(t_abs), f, d, cc, a});
    endtask

    task automatic dark(input int t_abs, input logic f);
        push(t_abs, 4'hF, 7'h7F, 1'b1, f);
    endtask

    // Driver helpers
    task automatic wait_t(input int t);
        while (cyc != base + t) @(negedge ck);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] e, input logic [3:0] br);
        digits     = d;
        dp         = p;
        digit_en   = e;
        brightness = br;
        load       = 1'b1;
        @(negedge ck);
        load       = 1'b0;
    endtask

    // Monitor: compare both instances whenever the head stamp is due
    initial mon_idx = 0;
    always @(negedge ck) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q[0];
            if (int'(mon_e[28:13]) == cyc) begin
                void'(exp_q.pop_front());
                checks = checks + 1;
                if ({fs0, dp0, c0, an0} !== mon_e[12:0]) begin
                    errors = errors + 1;
                    $display("FAIL chk%0d act_low @%0d: got an=%h c=%h dp=%b fs=%b, want an=%h c=%h dp=%b fs=%b",
                             mon_idx, cyc, an0, c0, dp0, fs0,
                             mon_e[3:0], mon_e[10:4], mon_e[11], mon_e[12]);
                end
                checks = checks + 1;
                if ({fs1, ~dp1, ~c1, ~an1} !== mon_e[12:0]) begin
                    errors = errors + 1;
                    $display("FAIL chk%0d act_high @%0d: got an=%h c=%h dp=%b fs=%b, want an=%h c=%h dp=%b fs=%b",
                             mon_idx, cyc, an1, c1, dp1, fs1,
                             ~mon_e[3:0], ~mon_e[10:4], ~mon_e[11], mon_e[12]);
                end
                mon_idx = mon_idx + 1;
            end else if (int'(mon_e[28:13]) < cyc) begin
                void'(exp_q.pop_front());
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL chk%0d missed: stamp %0d passed at %0d", mon_idx, mon_e[28:13], cyc);
                mon_idx = mon_idx + 1;
            end
        end
    end

    // Hand-computed expectation table (t = clocks since reset release)
    initial begin
        // reset / no load: dark, frame_start every 160 clocks
        dark(B1 + 0, 1'b0);   dark(B1 + 5, 1'b0);   dark(B1 + 45, 1'b0);
        dark(B1 + 100, 1'b0); dark(B1 + 159, 1'b0); dark(B1 + 160, 1'b1);
        dark(B1 + 161, 1'b0);
        // digits 3210, dp on digit 2, full brightness, active from t=320
        dark(B1 + 320, 1'b1); dark(B1 + 321, 1'b0); dark(B1 + 324, 1'b0);
        push(B1 + 325, 4'hE, 7'h01, 1'b1, 1'b0);
        push(B1 + 360, 4'hE, 7'h01, 1'b1, 1'b0);
        dark(B1 + 361, 1'b0); dark(B1 + 364, 1'b0);
        push(B1 + 365, 4'hD, 7'h4F, 1'b1, 1'b0);
        push(B1 + 405, 4'hB, 7'h12, 1'b0, 1'b0);
        push(B1 + 445, 4'h7, 7'h06, 1'b1, 1'b0);
        push(B1 + 480, 4'h7, 7'h06, 1'b1, 1'b1);
        push(B1 + 500, 4'hE, 7'h01, 1'b1, 1'b0);
        // brightness 4, active from t=640: lit on pwm 0..3 only
        push(B1 + 640, 4'h7, 7'h06, 1'b1, 1'b1);
        dark(B1 + 645, 1'b0); dark(B1 + 656, 1'b0);
        push(B1 + 657, 4'hE, 7'h01, 1'b1, 1'b0);
        push(B1 + 660, 4'hE, 7'h01, 1'b1, 1'b0);
        dark(B1 + 661, 1'b0);
        push(B1 + 673, 4'hE, 7'h01, 1'b1, 1'b0);
        push(B1 + 676, 4'hE, 7'h01, 1'b1, 1'b0);
        dark(B1 + 677, 1'b0); dark(B1 + 736, 1'b0);
        push(B1 + 737, 4'hB, 7'h12, 1'b0, 1'b0);
        // mid-frame load of FEDC: old frame untouched, new data from t=960
        dark(B1 + 850, 1'b0);
        push(B1 + 857, 4'hD, 7'h4F, 1'b1, 1'b0);
        push(B1 + 937, 4'h7, 7'h06, 1'b1, 1'b0);
        dark(B1 + 960, 1'b1);
        push(B1 + 965, 4'hE, 7'h31, 1'b1, 1'b0);
        push(B1 + 1005, 4'hD, 7'h42, 1'b1, 1'b0);
        push(B1 + 1045, 4'hB, 7'h30, 1'b1, 1'b0);
        push(B1 + 1085, 4'h7, 7'h38, 1'b1, 1'b0);
        // pending 0000 goes active at t=1120, coincident load waits to t=1280
        push(B1 + 1120, 4'h7, 7'h38, 1'b1, 1'b1);
        push(B1 + 1125, 4'hE, 7'h01, 1'b0, 1'b0);
        push(B1 + 1165, 4'hD, 7'h01, 1'b1, 1'b0);
        push(B1 + 1280, 4'h7, 7'h01, 1'b1, 1'b1);
        // 7654 with digit_en 1010
        dark(B1 + 1285, 1'b0); dark(B1 + 1300, 1'b0);
        push(B1 + 1325, 4'hD, 7'h24, 1'b1, 1'b0);
        dark(B1 + 1365, 1'b0);
        push(B1 + 1405, 4'h7, 7'h0F, 1'b1, 1'b0);
        // 3210 again from t=1440, then asynchronous reset in slot 2
        push(B1 + 1440, 4'h7, 7'h0F, 1'b1, 1'b1);
        push(B1 + 1445, 4'hE, 7'h01, 1'b1, 1'b0);
        push(B1 + 1530, 4'hB, 7'h12, 1'b0, 1'b0);
        dark(B1 + 1541, 1'b0);
        // after release: dark, scan restarted from digit 0
        dark(B2 + 0, 1'b0);   dark(B2 + 5, 1'b0);   dark(B2 + 159, 1'b0);
        dark(B2 + 160, 1'b1); dark(B2 + 165, 1'b0);
    end

    // Stimulus
    initial begin
        checks     = 0;
        errors     = 0;
        base       = 0;
        rst_n      = 1'b0;
        digits     = '0;
        dp         = '0;
        digit_en   = '0;
        brightness = 4'd0;
        load       = 1'b0;

        wait_t(B1);
        rst_n = 1'b1;
        base  = B1;

        wait_t(200);  do_load(16'h3210, 4'b0100, 4'hF, 4'd15);
        wait_t(489);  do_load(16'h3210, 4'b0100, 4'hF, 4'd4);
        wait_t(845);  do_load(16'hFEDC, 4'b0000, 4'hF, 4'd15);
        wait_t(1100); do_load(16'h0000, 4'b0001, 4'hF, 4'd15);
        wait_t(1119); do_load(16'h7654, 4'b0000, 4'b1010, 4'd15);
        wait_t(1300); do_load(16'h3210, 4'b0100, 4'hF, 4'd15);

        wait_t(1540);
        @(posedge ck);
        #1 rst_n = 1'b0;
        wait_t(1545);
        rst_n = 1'b1;
        base  = B2;

        wait_t(165);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge ck);
        if (exp_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

endmodule
